// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: write/read-back BIST controller for a single-port synchronous RAM.
// A Start rising edge latches a fill pattern, writes it to every word, reads every
// word back and counts words that differ from the pattern.
//
// Ports:
//   Clk            - clock, all state changes on the rising edge
//   Rst            - synchronous active-high reset
//   Start          - run request, acted on at its rising edge only
//   Pattern_Sel    - fill pattern: 00=all ones, 01=all zeros, 10=F0F0.., 11=AAAA..
//   M_R_Data       - RAM read data, valid one cycle after its address
//   Mem_Addr       - RAM word address
//   Mem_Write      - RAM write enable
//   M_W_Data       - RAM write data (zero outside the write phase)
//   Busy           - test in progress (WRITE, READ, DRAIN)
//   Done           - test finished, results held until next run or reset
//   Pass           - with Done, no mismatches found
//   Err_Cnt        - number of mismatching words
//   First_Err_Addr - address of the first mismatch (0 if none)
//   LED            - registered status display
module mem_bist_ctrl #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [1:0]        Pattern_Sel,
    input  logic [DATA_W-1:0] M_R_Data,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Write,
    output logic [DATA_W-1:0] M_W_Data,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [ADDR_W:0]   Err_Cnt,
    output logic [ADDR_W-1:0] First_Err_Addr,
    output logic [7:0]        LED
);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    localparam logic [ADDR_W-1:0] AddrLast = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        pat_sel_q, pat_sel_d;
    logic              start_d_q;
    logic              rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;
    logic [7:0]        led_q, led_d;

    logic              start_edge;
    logic [DATA_W-1:0] pattern;
    logic              busy_d;
    logic              pass_d;

    // Expected word for the latched pattern selection.
    always_comb begin
        pattern = '0;
        unique case (pat_sel_q)
            2'b00: pattern = '1;
            2'b01: pattern = '0;
            2'b10: begin
                for (int unsigned i = 0; i < DATA_W; i++) begin
                    pattern[i] = ((i / 4) % 2) == 1;
                end
            end
            2'b11: begin
                for (int unsigned i = 0; i < DATA_W; i++) begin
                    pattern[i] = (i % 2) == 1;
                end
            end
            default: pattern = '0;
        endcase
    end

    assign start_edge = Start & ~start_d_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pat_sel_d   = pat_sel_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        rd_vld_d    = 1'b0;
        rd_addr_d   = addr_q;

        // Compare stage: data for the address issued last cycle arrives now.
        if (rd_vld_q && (M_R_Data != pattern)) begin
            if (err_cnt_q == '0) begin
                first_err_d = rd_addr_q;
            end
            err_cnt_d = err_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start_edge) begin
                    pat_sel_d   = Pattern_Sel;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    addr_d      = '0;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                if (addr_q == AddrLast) begin
                    addr_d  = '0;
                    state_d = StRead;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StRead: begin
                rd_vld_d = 1'b1;
                if (addr_q == AddrLast) begin
                    addr_d  = '0;
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
                addr_d  = '0;
            end
        endcase
    end

    // LED is computed from next-state values so the registered display lines up
    // with Busy/Done in the same cycle. Layout assumes ADDR_W = 6.
    always_comb begin
        busy_d = (state_d == StWrite) || (state_d == StRead) || (state_d == StDrain);
        pass_d = (state_d == StDone) && (err_cnt_d == '0);
        led_d  = 8'h00;
        if (state_d == StDone) begin
            led_d = {pass_d, err_cnt_d};
        end else if (busy_d) begin
            led_d = {2'b10, addr_d};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            pat_sel_q   <= 2'b00;
            start_d_q   <= 1'b1;  // a Start held through reset is not an edge
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            led_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pat_sel_q   <= pat_sel_d;
            start_d_q   <= Start;
            rd_vld_q    <= rd_vld_d;
            rd_addr_q   <= rd_addr_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            led_q       <= led_d;
        end
    end

    assign Mem_Addr       = addr_q;
    assign Mem_Write      = (state_q == StWrite);
    assign M_W_Data       = (state_q == StWrite) ? pattern : '0;
    assign Busy           = (state_q == StWrite) || (state_q == StRead) || (state_q == StDrain);
    assign Done           = (state_q == StDone);
    assign Pass           = (state_q == StDone) && (err_cnt_q == '0);
    assign Err_Cnt        = err_cnt_q;
    assign First_Err_Addr = first_err_q;
    assign LED            = led_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Testbench for mem_bist_ctrl: synchronous RAM model with fault injection and a
// reference model that derives expected results from the RAM contents and pattern.
module tb_mem_bist_ctrl;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [1:0]  Pattern_Sel;
    logic [31:0] M_R_Data;
    logic [5:0]  Mem_Addr;
    logic        Mem_Write;
    logic [31:0] M_W_Data;
    logic        Busy;
    logic        Done;
    logic        Pass;
    logic [6:0]  Err_Cnt;
    logic [5:0]  First_Err_Addr;
    logic [7:0]  LED;

    int checks = 0;
    int errors = 0;

    // RAM model controls
    logic [31:0] mem [64];
    logic [63:0] bad_mask = 64'd0;
    logic [31:0] flip = 32'h1;
    bit          zero_mode = 1'b0;

    // Write monitor
    logic [31:0] exp_pat = 32'h0;
    int          wr_cnt = 0;
    int          wr_bad = 0;

    mem_bist_ctrl #(
        .ADDR_W(6),
        .DATA_W(32)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Start         (Start),
        .Pattern_Sel   (Pattern_Sel),
        .M_R_Data      (M_R_Data),
        .Mem_Addr      (Mem_Addr),
        .Mem_Write     (Mem_Write),
        .M_W_Data      (M_W_Data),
        .Busy          (Busy),
        .Done          (Done),
        .Pass          (Pass),
        .Err_Cnt       (Err_Cnt),
        .First_Err_Addr(First_Err_Addr),
        .LED           (LED)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (Mem_Write === 1'b1) begin
            mem[Mem_Addr] <= M_W_Data;
            wr_cnt = wr_cnt + 1;
            if (M_W_Data !== exp_pat) wr_bad = wr_bad + 1;
        end
        if (zero_mode) M_R_Data <= 32'h0;
        else M_R_Data <= mem[Mem_Addr] ^ (bad_mask[Mem_Addr] ? flip : 32'h0);
    end

    function automatic logic [31:0] exp_pattern(input logic [1:0] sel);
        case (sel)
            2'b00:   return 32'hFFFF_FFFF;
            2'b01:   return 32'h0000_0000;
            2'b10:   return 32'hF0F0_F0F0;
            default: return 32'hAAAA_AAAA;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One full run; restart_at > 0 re-pulses Start in that cycle, chg_sel alters
    // Pattern_Sel mid-run. Cycle n below is t+n where t is the Start-edge cycle.
    task automatic run_test(input string name, input logic [1:0] sel, input int restart_at,
                            input bit chg_sel);
        logic [31:0] pat;
        logic [31:0] rd;
        int          exp_errs;
        int          exp_first;
        int          done_cyc;
        int          seq_bad;
        int          wr_base;
        int          wbad_base;
        bit          exp_pass;
        logic [6:0]  err_hold;

        pat       = exp_pattern(sel);
        exp_pat   = pat;
        exp_errs  = 0;
        exp_first = 0;
        for (int a = 0; a < 64; a++) begin
            rd = zero_mode ? 32'h0 : (pat ^ (bad_mask[a] ? flip : 32'h0));
            if (rd != pat) begin
                if (exp_errs == 0) exp_first = a;
                exp_errs++;
            end
        end
        exp_pass = (exp_errs == 0);

        Start       = 1'b0;
        Pattern_Sel = sel;
        tick();
        wr_base   = wr_cnt;
        wbad_base = wr_bad;
        Start     = 1'b1;
        tick();
        Start = 1'b0;

        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0 || Pass !== 1'b0 || Err_Cnt !== 7'd0 ||
            First_Err_Addr !== 6'd0) begin
            errors++;
            $display("FAIL %s_entry: Busy=%b Done=%b Pass=%b Err_Cnt=%0d First=%0d required 1 0 0 0 0",
                     name, Busy, Done, Pass, Err_Cnt, First_Err_Addr);
        end

        done_cyc = -1;
        seq_bad  = 0;
        for (int n = 1; n <= 300; n++) begin
            if (Done === 1'b1) begin
                done_cyc = n;
                break;
            end
            if (n <= 64) begin
                if (Mem_Write !== 1'b1 || Mem_Addr !== 6'(n - 1) || Busy !== 1'b1 ||
                    LED !== {2'b10, 6'(n - 1)}) seq_bad++;
            end else if (n <= 128) begin
                if (Mem_Write !== 1'b0 || Mem_Addr !== 6'(n - 65) || M_W_Data !== 32'h0 ||
                    Busy !== 1'b1 || LED !== {2'b10, 6'(n - 65)}) seq_bad++;
            end else begin
                if (Mem_Write !== 1'b0 || Busy !== 1'b1 || M_W_Data !== 32'h0) seq_bad++;
            end
            if (chg_sel && n == 20) Pattern_Sel = ~sel;
            if (restart_at > 0 && n == restart_at) Start = 1'b1;
            if (restart_at > 0 && n == restart_at + 1) Start = 1'b0;
            tick();
        end

        checks++;
        if (done_cyc != 130) begin
            errors++;
            $display("FAIL %s_done_time: Done seen at t+%0d required t+130", name, done_cyc);
        end
        checks++;
        if (seq_bad != 0) begin
            errors++;
            $display("FAIL %s_sequence: %0d bad cycles required 0", name, seq_bad);
        end
        checks++;
        if (wr_cnt - wr_base != 64 || wr_bad - wbad_base != 0) begin
            errors++;
            $display("FAIL %s_writes: %0d writes %0d wrong data required 64 writes 0 wrong",
                     name, wr_cnt - wr_base, wr_bad - wbad_base);
        end
        checks++;
        if (Err_Cnt !== 7'(exp_errs) || First_Err_Addr !== 6'(exp_first)) begin
            errors++;
            $display("FAIL %s_errors: Err_Cnt=%0d First=%0d required %0d %0d",
                     name, Err_Cnt, First_Err_Addr, exp_errs, exp_first);
        end
        checks++;
        if (Pass !== exp_pass || LED !== {exp_pass, 7'(exp_errs)} || Busy !== 1'b0 ||
            Mem_Write !== 1'b0 || Mem_Addr !== 6'd0) begin
            errors++;
            $display("FAIL %s_done_outputs: Pass=%b LED=%h Busy=%b Wr=%b Addr=%0d required %b %h 0 0 0",
                     name, Pass, LED, Busy, Mem_Write, Mem_Addr, exp_pass,
                     {exp_pass, 7'(exp_errs)});
        end

        err_hold = 7'(exp_errs);
        repeat (3) tick();
        checks++;
        if (Done !== 1'b1 || Err_Cnt !== err_hold || Pass !== exp_pass) begin
            errors++;
            $display("FAIL %s_hold: Done=%b Err_Cnt=%0d Pass=%b required 1 %0d %b",
                     name, Done, Err_Cnt, Pass, err_hold, exp_pass);
        end
    endtask

    task automatic test_reset();
        Rst         = 1'b1;
        Start       = 1'b0;
        Pattern_Sel = 2'b00;
        repeat (3) tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Pass !== 1'b0 || Mem_Write !== 1'b0 ||
            Mem_Addr !== 6'd0 || M_W_Data !== 32'h0 || Err_Cnt !== 7'd0 ||
            First_Err_Addr !== 6'd0 || LED !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: Busy=%b Done=%b Pass=%b Wr=%b Addr=%0d WData=%h Err=%0d LED=%h required all 0",
                     Busy, Done, Pass, Mem_Write, Mem_Addr, M_W_Data, Err_Cnt, LED);
        end
        Rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: Busy=%b Done=%b required 0 0", Busy, Done);
        end
    endtask

    task automatic test_reset_mid_run();
        int busy_seen;
        int wr_snap;

        // Reset during READ with Start held high through release.
        exp_pat = exp_pattern(2'b11);
        Pattern_Sel = 2'b11;
        Start = 1'b0;
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (69) tick();
        Rst   = 1'b1;
        Start = 1'b1;
        tick();
        checks++;
        if (Busy !== 1'b0 || Mem_Write !== 1'b0 || LED !== 8'h00 || Done !== 1'b0 ||
            Err_Cnt !== 7'd0 || Mem_Addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_in_read: Busy=%b Wr=%b LED=%h Done=%b Err=%0d Addr=%0d required 0",
                     Busy, Mem_Write, LED, Done, Err_Cnt, Mem_Addr);
        end
        tick();
        Rst = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (Busy !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin
            errors++;
            $display("FAIL start_held_through_reset: busy for %0d cycles required 0", busy_seen);
        end

        // Reset during WRITE must stop writes at the same edge.
        Start = 1'b0;
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        Rst = 1'b1;
        tick();
        wr_snap = wr_cnt;
        checks++;
        if (Mem_Write !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_write: Wr=%b Busy=%b required 0 0", Mem_Write, Busy);
        end
        Rst = 1'b0;
        tick();
        checks++;
        if (wr_cnt != wr_snap) begin
            errors++;
            $display("FAIL write_after_reset: %0d writes required 0", wr_cnt - wr_snap);
        end
    endtask

    task automatic test_pass_run();
        bad_mask  = 64'd0;
        zero_mode = 1'b0;
        run_test("pass_aa", 2'b11, 0, 1'b0);
    endtask

    task automatic test_corrupt();
        bad_mask  = (64'd1 << 5) | (64'd1 << 40);
        flip      = $urandom | 32'h1;
        zero_mode = 1'b0;
        run_test("corrupt_f0", 2'b10, 0, 1'b0);
        bad_mask = 64'd0;
    endtask

    task automatic test_all_zero();
        zero_mode = 1'b1;
        run_test("all_zero", 2'b00, 0, 1'b0);
        zero_mode = 1'b0;
    endtask

    task automatic test_restart_ignored();
        run_test("restart", 2'(($urandom % 3) + 1), 30, 1'b1);
    endtask

    task automatic test_back_to_back();
        // Starts from DONE holding 64 errors from the all-zero run.
        run_test("back_to_back", 2'b01, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            bad_mask = 64'd0;
            for (int k = 0; k < int'($urandom_range(0, 5)); k++) begin
                bad_mask[$urandom_range(0, 63)] = 1'b1;
            end
            flip = $urandom | 32'h1;
            run_test("random", 2'($urandom), 0, 1'b0);
        end
        bad_mask = 64'd0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst         = 1'b1;
        Start       = 1'b0;
        Pattern_Sel = 2'b00;
        test_reset();
        test_pass_run();
        test_corrupt();
        test_all_zero();
        test_back_to_back();
        test_restart_ignored();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6: RAM word-address width; the RAM holds 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 32: RAM word width.
REQ-003 Port Clk  in  1: single clock; all state changes on the rising edge.
REQ-004 Port Rst  in  1: synchronous, active-high reset.
REQ-005 Port Start  in  1: debounced run request; acted on at its rising edge only.
REQ-006 Port Pattern_Sel  in  2: selects the fill pattern (00=FFFF_FFFF, 01=0000_0000, 10=F0F0_F0F0, 11=AAAA_AAAA).
REQ-007 Port M_R_Data  in  DATA_W: RAM read data, valid one cycle after its address is presented.
REQ-008 Port Mem_Addr  out  ADDR_W: RAM word address.
REQ-009 Port Mem_Write  out  1: RAM write enable.
REQ-010 Port M_W_Data  out  DATA_W: RAM write data.
REQ-011 Port Busy  out  1: high while a test is running.
REQ-012 Port Done  out  1: high from test completion until the next run or reset.
REQ-013 Port Pass  out  1: high with Done when no mismatches were found.
REQ-014 Port Err_Cnt  out  ADDR_W+1: count of mismatching words.
REQ-015 Port First_Err_Addr  out  ADDR_W: address of the first mismatch (0 if none).
REQ-016 Port LED  out  8: status display.

Function
REQ-017 States SHALL be IDLE, WRITE, READ, DRAIN and DONE, encoded in one registered state variable.
REQ-018 A registered copy Start_d SHALL drive edge detection; the edge condition is Start & ~Start_d.
REQ-019 On a Start edge in IDLE or DONE, the block SHALL latch Pattern_Sel, clear Err_Cnt, First_Err_Addr, Pass and Done, and enter WRITE with Mem_Addr=0 on the next cycle.
REQ-020 A Start edge in WRITE, READ or DRAIN SHALL be ignored; Pattern_Sel changes after latching SHALL be ignored.
REQ-021 In WRITE, outputs SHALL be Mem_Write=1 and M_W_Data=latched pattern; Mem_Addr SHALL increment by 1 each cycle from 0 to 2^ADDR_W-1, then the state becomes READ with Mem_Addr=0.
REQ-022 In READ, Mem_Write SHALL be 0 and Mem_Addr SHALL increment from 0 to 2^ADDR_W-1 once per cycle; after the last address the state becomes DRAIN.
REQ-023 The compare pipeline SHALL use a 1-cycle delayed valid flag and address: in the cycle after each READ address, M_R_Data SHALL be compared with the latched pattern.
REQ-024 DRAIN SHALL last exactly one cycle, comparing the final address, then enter DONE.
REQ-025 On each mismatch, Err_Cnt SHALL increment by 1; the maximum value 2^ADDR_W fits without wrap.
REQ-026 On the first mismatch only, First_Err_Addr SHALL capture the delayed address.
REQ-027 Timing, with a Start edge seen in cycle t: WRITE runs t+1..t+64, READ runs t+65..t+128, DRAIN is t+129, and Done=1 from t+130 (ADDR_W=6).
REQ-028 Busy SHALL be 1 in WRITE, READ and DRAIN only.
REQ-029 In DONE: Done=1, Pass=(Err_Cnt==0), Mem_Write=0 and Mem_Addr=0; results are held until the next Start edge or reset.
REQ-030 In IDLE: Mem_Write=0, Mem_Addr=0 and M_W_Data=0.
REQ-031 LED SHALL show {Pass, Err_Cnt[6:0]} when Done=1, {1'b1, 1'b0, Mem_Addr} when Busy=1, and 8'h00 otherwise (registered, ADDR_W=6).
REQ-032 M_W_Data SHALL be 0 in every state except WRITE.

Reset
REQ-033 When Rst=1 at a rising edge, the block SHALL enter IDLE, clear all outputs to 0 and set Start_d=1, regardless of state.
REQ-034 A reset during WRITE SHALL deassert Mem_Write at the same edge, so no write is issued in the cycle after reset.
REQ-035 A Start held high across reset release SHALL NOT launch a run; a new rising edge is required.

Verification
REQ-036 Pattern_Sel=11, Start pulse, ideal RAM model -> 64 writes of AAAA_AAAA, Done at t+130, Pass=1, Err_Cnt=0, LED=8'h80.
REQ-037 RAM model corrupts words 5 and 40 on read, Pattern_Sel=10 -> Err_Cnt=2, First_Err_Addr=5, Pass=0, LED=8'h02.
REQ-038 RAM model returns all-zero data, Pattern_Sel=00 -> Err_Cnt=64, Pass=0, LED=8'h40.
REQ-039 Start re-pulsed at cycle t+30, and Pattern_Sel changed mid-run -> no restart, original pattern used, Done still at t+130.
REQ-040 Rst asserted at t+70 (during READ) -> next cycle IDLE, Busy=0, Mem_Write=0, LED=0; Start held high through reset release does not start a run.
REQ-041 Second Start edge in DONE with Pattern_Sel=01 -> results cleared on entry to WRITE, new run passes, Err_Cnt=0.
